// File: rtl/decoder_nto2n_seq_if.sv
// ----------------------------------------------------------------------------
// decoder_nto2n_seq_if
// Bundles the control and result signals of decoder_nto2n_seq.
//   master : drives en, mode, i, i_valid; receives d, d_valid, idx, wrap
//   slave  : the decoder side (receives controls, drives results)
// Parameter N : select width; d is 2^N bits wide.
// ----------------------------------------------------------------------------
interface decoder_nto2n_seq_if #(
   parameter int N = 2
) ();
   localparam int M = 1 << N;

   logic         en;       // clock enable
   logic         mode;     // 0 = direct decode, 1 = scan
   logic [N-1:0] i;        // select value (direct mode only)
   logic         i_valid;  // qualifies i
   logic [M-1:0] d;        // registered one-hot (or one-cold) output
   logic         d_valid;  // strobe: d was newly loaded
   logic [N-1:0] idx;      // index of the set bit of d
   logic         wrap;     // scan wrapped from 2^N-1 to 0

   modport master (
      output en, mode, i, i_valid,
      input  d, d_valid, idx, wrap
   );

   modport slave (
      input  en, mode, i, i_valid,
      output d, d_valid, idx, wrap
   );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// ----------------------------------------------------------------------------
// decoder_nto2n_seq
// Registered N-to-2^N one-hot decoder with an autonomous, prescaled scan mode.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : decoder_nto2n_seq_if.slave
//            en, mode, i, i_valid  -> inputs
//            d, d_valid, idx, wrap -> registered outputs
// Parameters:
//   N        : select width (>= 1), output width 2^N
//   SCAN_DIV : enabled clock cycles per scan step (>= 1)
// Build option:
//   DEC_ACTIVE_LOW_EN : when defined, d is presented inverted (one-cold);
//                       the reset value of d then reads as all ones.
// ----------------------------------------------------------------------------
module decoder_nto2n_seq #(
   parameter int N        = 2,
   parameter int SCAN_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   decoder_nto2n_seq_if.slave  bus
);
   localparam int M  = 1 << N;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

   typedef enum logic {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   state_t        r_state;
   logic [M-1:0]  r_d;        // always stored active-high
   logic          r_d_valid;
   logic [N-1:0]  r_idx;
   logic          r_wrap;
   logic [PW-1:0] r_pre;

   logic [N-1:0]  w_next_idx;
   logic [M-1:0]  w_load_d;
   logic [M-1:0]  w_step_d;

   // N-bit add wraps modulo 2^N by itself.
   assign w_next_idx = r_idx + N'(1);
   assign w_load_d   = M'(1) << bus.i;
   assign w_step_d   = M'(1) << w_next_idx;

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_DIRECT;
         r_d       <= '0;
         r_d_valid <= 1'b0;
         r_idx     <= '0;
         r_wrap    <= 1'b0;
         r_pre     <= '0;
      end else if (!bus.en) begin
         // Stall: state, d, idx and prescaler hold; strobes drop.
         r_d_valid <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         // Strobes default low; the branches below raise them when needed.
         r_d_valid <= 1'b0;
         r_wrap    <= 1'b0;
         case (r_state)
            ST_DIRECT: begin
               if (bus.mode) begin
                  // Mode change wins over a simultaneous i_valid.
                  r_state   <= ST_SCAN;
                  r_idx     <= '0;
                  r_d       <= M'(1);
                  r_pre     <= '0;
                  r_d_valid <= 1'b1;
               end else if (bus.i_valid) begin
                  r_d       <= w_load_d;
                  r_idx     <= bus.i;
                  r_d_valid <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (!bus.mode) begin
                  r_state <= ST_DIRECT;
                  r_pre   <= '0;
               end else if (r_pre == PRE_LAST) begin
                  r_pre     <= '0;
                  r_idx     <= w_next_idx;
                  r_d       <= w_step_d;
                  r_d_valid <= 1'b1;
                  r_wrap    <= &r_idx;
               end else begin
                  r_pre <= r_pre + PW'(1);
               end
            end
            default: r_state <= ST_DIRECT;
         endcase
      end
   end

`ifdef DEC_ACTIVE_LOW_EN
   assign bus.d = ~r_d;
`else
   assign bus.d = r_d;
`endif
   assign bus.d_valid = r_d_valid;
   assign bus.idx     = r_idx;
   assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_nto2n_seq
// Directed bench for decoder_nto2n_seq with N=2, SCAN_DIV=3. Inputs change
// 1 ns after a rising edge; outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_decoder_nto2n_seq;
   localparam int N        = 2;
   localparam int SCAN_DIV = 3;
   localparam int M        = 1 << N;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   decoder_nto2n_seq_if #(.N(N)) bus ();

   decoder_nto2n_seq #(
      .N        (N),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected pin value of d for an active-high pattern.
   function automatic logic [M-1:0] pin_d(input logic [M-1:0] v);
`ifdef DEC_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [M-1:0] e_d,
                            input logic e_dv, input logic [N-1:0] e_idx,
                            input logic e_wrap);
      check({tag, ".d"},       32'(bus.d),       32'(pin_d(e_d)));
      check({tag, ".d_valid"}, 32'(bus.d_valid), 32'(e_dv));
      check({tag, ".idx"},     32'(bus.idx),     32'(e_idx));
      check({tag, ".wrap"},    32'(bus.wrap),    32'(e_wrap));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.en        = 1'b0;
      bus.mode      = 1'b0;
      bus.i         = '0;
      bus.i_valid   = 1'b0;

      // Reset held two cycles.
      tick();
      tick();
      check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;

      // Single direct decode, then idle hold.
      bus.en = 1'b1; bus.i = 2'd2; bus.i_valid = 1'b1;
      tick();
      check_out("dir_i2", 4'b0100, 1'b1, 2'd2, 1'b0);
      bus.i_valid = 1'b0;
      tick();
      check_out("dir_hold", 4'b0100, 1'b0, 2'd2, 1'b0);

      // Back-to-back decodes.
      bus.i_valid = 1'b1;
      bus.i = 2'd0; tick(); check_out("b2b_0", 4'b0001, 1'b1, 2'd0, 1'b0);
      bus.i = 2'd1; tick(); check_out("b2b_1", 4'b0010, 1'b1, 2'd1, 1'b0);
      bus.i = 2'd2; tick(); check_out("b2b_2", 4'b0100, 1'b1, 2'd2, 1'b0);
      bus.i = 2'd3; tick(); check_out("b2b_3", 4'b1000, 1'b1, 2'd3, 1'b0);
      bus.i_valid = 1'b0;

      // Scan entry, full sweep with wrap.
      bus.mode = 1'b1;
      tick(); check_out("scan_entry", 4'b0001, 1'b1, 2'd0, 1'b0);
      tick(); check_out("scan_p1",    4'b0001, 1'b0, 2'd0, 1'b0);
      tick(); check_out("scan_p2",    4'b0001, 1'b0, 2'd0, 1'b0);
      tick(); check_out("scan_s1",    4'b0010, 1'b1, 2'd1, 1'b0);
      tick(); tick();
      check_out("scan_pre_s2", 4'b0010, 1'b0, 2'd1, 1'b0);
      tick(); check_out("scan_s2",    4'b0100, 1'b1, 2'd2, 1'b0);
      tick(); tick();
      tick(); check_out("scan_s3",    4'b1000, 1'b1, 2'd3, 1'b0);
      tick(); tick();
      check_out("scan_pre_wrap", 4'b1000, 1'b0, 2'd3, 1'b0);
      tick(); check_out("scan_wrap",  4'b0001, 1'b1, 2'd0, 1'b1);
      tick(); check_out("scan_after_wrap", 4'b0001, 1'b0, 2'd0, 1'b0);

      // Stall for 5 cycles with prescaler at 1; it must resume at 1, not 0.
      bus.en = 1'b0;
      tick(); check_out("stall_1", 4'b0001, 1'b0, 2'd0, 1'b0);
      tick(); tick(); tick();
      tick(); check_out("stall_5", 4'b0001, 1'b0, 2'd0, 1'b0);
      bus.en = 1'b1;
      tick(); check_out("resume_p2", 4'b0001, 1'b0, 2'd0, 1'b0);
      tick(); check_out("resume_step", 4'b0010, 1'b1, 2'd1, 1'b0);
      tick(); tick();
      tick(); check_out("scan_to_0100", 4'b0100, 1'b1, 2'd2, 1'b0);

      // Exit scan: d holds, no strobe.
      bus.mode = 1'b0;
      tick(); check_out("exit_hold", 4'b0100, 1'b0, 2'd2, 1'b0);

      // Mode beats i_valid on entry.
      bus.mode = 1'b1; bus.i = 2'd3; bus.i_valid = 1'b1;
      tick(); check_out("mode_prio", 4'b0001, 1'b1, 2'd0, 1'b0);
      // i/i_valid ignored while scanning.
      tick(); check_out("scan_ignores_i", 4'b0001, 1'b0, 2'd0, 1'b0);
      tick();

      // Reset mid-scan, with en low, on what would be a step edge.
      rst = 1'b1; bus.en = 1'b0;
      tick(); check_out("rst_mid_scan", 4'b0000, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;

      // Back in DIRECT: mode=0 with i_valid decodes immediately.
      bus.en = 1'b1; bus.mode = 1'b0; bus.i = 2'd1; bus.i_valid = 1'b1;
      tick(); check_out("post_rst_direct", 4'b0010, 1'b1, 2'd1, 1'b0);

      // en low blocks a direct load.
      bus.en = 1'b0; bus.i = 2'd3;
      tick(); check_out("en_low_direct", 4'b0010, 1'b0, 2'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
